dcache_victim_ctrl: RTL and testbench
=====================================

DCACHE_VICTIM_CTRL -- requirements
Module: dcache_victim_ctrl

Interface
REQ-001 Parameter IDX_BITS, default 7, width of the cache set index and of the flush counter (2^IDX_BITS sets).
REQ-002 clk  in  1  clock; all state updates on the rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 lsummu2dcache_req_i  in  1  LSU/MMU access request, held until ack.
REQ-005 lsummu2dcache_wr_i  in  1  1 = store, 0 = load; sampled with req in IDLE.
REQ-006 dcache_flush_i  in  1  flush request, held until flush ack.
REQ-007 cache_hit_i / cache_evict_req_i / cache_valid_i  in  1 each  tag-RAM result for the indexed line: tag match, dirty, valid.
REQ-008 victim_hit_i  in  1  victim cache holds the missing line.
REQ-009 mem2dcache_ack_i  in  1  memory transfer complete.
REQ-010 dcache2lsummu_ack_o  out  1  access complete, one-cycle pulse.
REQ-011 dcache_flush_ack_o  out  1  flush complete, one-cycle pulse.
REQ-012 cache_wr_o / cache_line_wr_o / cache_line_clean_o / cache_wrb_req_o  out  1 each  datapath word write, line fill, dirty clear, writeback address select.
REQ-013 write_to_victim_o / write_from_victim_o  out  1 each  victim capture / victim-to-cache line write.
REQ-014 dcache2mem_req_o / dcache2mem_wr_o  out  1 each  memory request, held until ack; 1 = write.
REQ-015 evict_index_o  out  IDX_BITS  flush index counter.

Function
REQ-016 States: IDLE, LOOKUP, SWAP, WRITEBACK, ALLOCATE, FLUSH_RD, FLUSH_CHK, FLUSH_WB, FLUSH_DONE.
REQ-017 IDLE: flush_i -> FLUSH_RD with counter 0 (flush wins over a simultaneous req); else req_i -> LOOKUP, latch wr_i.
REQ-018 LOOKUP: evaluates tag/victim inputs one cycle after RAM read issue.
REQ-019 LOOKUP hit, load: ack_o pulse -> IDLE; hit, store: cache_wr_o and ack_o same cycle -> IDLE.
REQ-020 LOOKUP miss, victim_hit_i=1, line not dirty: -> SWAP.
REQ-021 SWAP (one cycle): write_to_victim_o and write_from_victim_o asserted together -> LOOKUP (re-lookup hits).
REQ-022 LOOKUP miss, line valid and dirty: -> WRITEBACK regardless of victim_hit_i.
REQ-023 LOOKUP miss, no victim hit, line not dirty: write_to_victim_o pulsed that cycle iff cache_valid_i=1; -> ALLOCATE.
REQ-024 WRITEBACK: cache_wrb_req_o=1, mem_req_o=1, mem_wr_o=1 until ack; on ack -> LOOKUP (line now clean, re-evaluated).
REQ-025 ALLOCATE: mem_req_o=1, mem_wr_o=0 until ack; on ack cache_line_wr_o pulses one cycle -> LOOKUP.
REQ-026 mem2dcache_ack_i outside WRITEBACK/ALLOCATE/FLUSH_WB is ignored.
REQ-027 FLUSH_RD: evict_index_o = counter, RAM read issued -> FLUSH_CHK.
REQ-028 FLUSH_CHK: dirty -> FLUSH_WB; clean -> counter+1 and FLUSH_RD, or FLUSH_DONE if counter = 2^IDX_BITS-1.
REQ-029 FLUSH_WB: cache_wrb_req_o, mem_req_o, mem_wr_o held until ack; on ack cache_line_clean_o pulses, then same advance rule as REQ-028.
REQ-030 FLUSH_DONE: dcache_flush_ack_o pulse -> IDLE; counter wraps to 0.
REQ-031 All datapath strobes are single-cycle except mem_req/mem_wr/wrb_req, which hold constant until ack.
REQ-032 At most one of cache_wr_o, cache_line_wr_o, cache_line_clean_o, write_from_victim_o is high per cycle.

Reset
REQ-033 rst_n=0 at a clock edge: state IDLE, counter 0, latched wr 0, every output 0, including mid-transfer (memory request dropped without waiting for ack).

Verification
REQ-034 Load hit: req=1, wr=0, hit=1 in LOOKUP -> ack_o at cycle 2, no other strobe.
REQ-035 Store miss, clean valid line, no victim hit: write_to_victim_o at cycle 2, mem read req until ack at cycle 6, cache_line_wr_o cycle 7, cache_wr_o + ack_o cycle 8.
REQ-036 Load miss, victim_hit=1, clean: SWAP strobes both high cycle 3, ack_o cycle 4, no memory request.
REQ-037 Miss on dirty line with victim_hit=1: WRITEBACK precedes SWAP; mem_wr_o=1 held until ack.
REQ-038 Flush with IDX_BITS=2, lines 1 and 3 dirty: exactly two writebacks, two cache_line_clean_o pulses, evict_index_o sequence 0..3, one dcache_flush_ack_o.
REQ-039 rst_n=0 during ALLOCATE with mem_req_o=1 -> next cycle all outputs 0, state IDLE; later ack ignored.

Source files
------------

// File: rtl/dcache_victim_ctrl.sv
// rtl/dcache_victim_ctrl.sv - data cache miss/victim/flush sequencing FSM
module dcache_victim_ctrl #(
    parameter int IDX_BITS = 7
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                lsummu2dcache_req_i,
    input  logic                lsummu2dcache_wr_i,
    input  logic                dcache_flush_i,
    input  logic                cache_hit_i,
    input  logic                cache_evict_req_i,
    input  logic                cache_valid_i,
    input  logic                victim_hit_i,
    input  logic                mem2dcache_ack_i,
    output logic                dcache2lsummu_ack_o,
    output logic                dcache_flush_ack_o,
    output logic                cache_wr_o,
    output logic                cache_line_wr_o,
    output logic                cache_line_clean_o,
    output logic                cache_wrb_req_o,
    output logic                write_to_victim_o,
    output logic                write_from_victim_o,
    output logic                dcache2mem_req_o,
    output logic                dcache2mem_wr_o,
    output logic [IDX_BITS-1:0] evict_index_o
);

    typedef enum logic [3:0] {
        IDLE, LOOKUP, SWAP, WRITEBACK, ALLOCATE,
        FLUSH_RD, FLUSH_CHK, FLUSH_WB, FLUSH_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_BITS-1:0] cnt_q, cnt_d;
    logic                wr_q, wr_d;
    logic                fill_q, fill_d;
    logic                dirty;
    logic                last_line;

    // An invalid line is never treated as dirty.
    assign dirty         = cache_evict_req_i && cache_valid_i;
    assign last_line     = (cnt_q == {IDX_BITS{1'b1}});
    assign evict_index_o = cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            fill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            fill_q  <= fill_d;
        end
    end

    always_comb begin
        state_d             = state_q;
        cnt_d               = cnt_q;
        wr_d                = wr_q;
        fill_d              = fill_q;
        dcache2lsummu_ack_o = 1'b0;
        dcache_flush_ack_o  = 1'b0;
        cache_wr_o          = 1'b0;
        cache_line_wr_o     = 1'b0;
        cache_line_clean_o  = 1'b0;
        cache_wrb_req_o     = 1'b0;
        write_to_victim_o   = 1'b0;
        write_from_victim_o = 1'b0;
        dcache2mem_req_o    = 1'b0;
        dcache2mem_wr_o     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (dcache_flush_i) begin
                    cnt_d   = '0;
                    state_d = FLUSH_RD;
                end else if (lsummu2dcache_req_i) begin
                    wr_d    = lsummu2dcache_wr_i;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (cache_hit_i) begin
                    dcache2lsummu_ack_o = 1'b1;
                    cache_wr_o          = wr_q;
                    state_d             = IDLE;
                end else if (dirty) begin
                    state_d = WRITEBACK;
                end else if (victim_hit_i) begin
                    state_d = SWAP;
                end else begin
                    write_to_victim_o = cache_valid_i;
                    state_d           = ALLOCATE;
                end
            end
            SWAP: begin
                write_to_victim_o   = 1'b1;
                write_from_victim_o = 1'b1;
                state_d             = LOOKUP;
            end
            WRITEBACK: begin
                cache_wrb_req_o  = 1'b1;
                dcache2mem_req_o = 1'b1;
                dcache2mem_wr_o  = 1'b1;
                if (mem2dcache_ack_i) state_d = LOOKUP;
            end
            ALLOCATE: begin
                // Fill data lands one cycle after the ack, then the line is re-read.
                if (fill_q) begin
                    cache_line_wr_o = 1'b1;
                    fill_d          = 1'b0;
                    state_d         = LOOKUP;
                end else begin
                    dcache2mem_req_o = 1'b1;
                    if (mem2dcache_ack_i) fill_d = 1'b1;
                end
            end
            FLUSH_RD: state_d = FLUSH_CHK;
            FLUSH_CHK: begin
                if (dirty) begin
                    state_d = FLUSH_WB;
                end else if (last_line) begin
                    state_d = FLUSH_DONE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = FLUSH_RD;
                end
            end
            FLUSH_WB: begin
                cache_wrb_req_o  = 1'b1;
                dcache2mem_req_o = 1'b1;
                dcache2mem_wr_o  = 1'b1;
                if (mem2dcache_ack_i) begin
                    cache_line_clean_o = 1'b1;
                    if (last_line) begin
                        state_d = FLUSH_DONE;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = FLUSH_RD;
                    end
                end
            end
            FLUSH_DONE: begin
                dcache_flush_ack_o = 1'b1;
                cnt_d              = '0;
                state_d            = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dcache_victim_ctrl.sv
// tb/tb_dcache_victim_ctrl.sv - directed self-checking bench for dcache_victim_ctrl
module tb_dcache_victim_ctrl;

    localparam int IDX_BITS = 2;

    logic clk = 1'b0;
    logic rst_n, req, wr, flush, hit, evict, valid, vhit, mack;
    logic ack, fack, cwr, lwr, clean, wrb, tov, fromv, mreq, mwr;
    logic [IDX_BITS-1:0] idx;
    logic [9:0] outs;
    int checks = 0;
    int errors = 0;

    localparam logic [9:0] NONE  = 10'b00_0000_0000;
    localparam logic [9:0] ACK   = 10'b10_0000_0000;
    localparam logic [9:0] FACK  = 10'b01_0000_0000;
    localparam logic [9:0] CWR   = 10'b00_1000_0000;
    localparam logic [9:0] LWR   = 10'b00_0100_0000;
    localparam logic [9:0] CLEAN = 10'b00_0010_0000;
    localparam logic [9:0] WRB   = 10'b00_0001_0000;
    localparam logic [9:0] TOV   = 10'b00_0000_1000;
    localparam logic [9:0] FROMV = 10'b00_0000_0100;
    localparam logic [9:0] MREQ  = 10'b00_0000_0010;
    localparam logic [9:0] MWR   = 10'b00_0000_0001;

    always #5 clk = ~clk;

    assign outs = {ack, fack, cwr, lwr, clean, wrb, tov, fromv, mreq, mwr};

    dcache_victim_ctrl #(.IDX_BITS(IDX_BITS)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .lsummu2dcache_req_i (req),
        .lsummu2dcache_wr_i  (wr),
        .dcache_flush_i      (flush),
        .cache_hit_i         (hit),
        .cache_evict_req_i   (evict),
        .cache_valid_i       (valid),
        .victim_hit_i        (vhit),
        .mem2dcache_ack_i    (mack),
        .dcache2lsummu_ack_o (ack),
        .dcache_flush_ack_o  (fack),
        .cache_wr_o          (cwr),
        .cache_line_wr_o     (lwr),
        .cache_line_clean_o  (clean),
        .cache_wrb_req_o     (wrb),
        .write_to_victim_o   (tov),
        .write_from_victim_o (fromv),
        .dcache2mem_req_o    (mreq),
        .dcache2mem_wr_o     (mwr),
        .evict_index_o       (idx)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [9:0] exp);
        #2;
        checks++;
        assert (outs === exp) else begin
            errors++;
            $error("FAIL %s outs=%b expected=%b", tag, outs, exp);
        end
    endtask

    task automatic chk_idx(input string tag, input logic [IDX_BITS-1:0] exp);
        checks++;
        assert (idx === exp) else begin
            errors++;
            $error("FAIL %s evict_index=%0d expected=%0d", tag, idx, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; req = 1'b0; wr = 1'b0; flush = 1'b0; hit = 1'b0;
        evict = 1'b0; valid = 1'b0; vhit = 1'b0; mack = 1'b0;
        cyc(); cyc();
        chk("reset_outs", NONE);
        chk_idx("reset_idx", 2'd0);
        rst_n = 1'b1;
        cyc();

        // Load hit
        req = 1'b1; wr = 1'b0; hit = 1'b0;
        chk("ldhit_c1", NONE); cyc();
        hit = 1'b1;
        chk("ldhit_c2_ack", ACK); cyc();
        req = 1'b0; hit = 1'b0;
        chk("ldhit_c3_idle", NONE); cyc();

        // Store miss, clean valid line, no victim hit
        req = 1'b1; wr = 1'b1; valid = 1'b1; evict = 1'b0; vhit = 1'b0;
        chk("stmiss_c1", NONE); cyc();
        chk("stmiss_c2_tov", TOV); cyc();
        wr = 1'b0;
        chk("stmiss_c3_mreq", MREQ); cyc();
        chk("stmiss_c4_mreq", MREQ); cyc();
        chk("stmiss_c5_mreq", MREQ); cyc();
        mack = 1'b1;
        chk("stmiss_c6_mreq_ack", MREQ); cyc();
        mack = 1'b0;
        chk("stmiss_c7_linewr", LWR); cyc();
        hit = 1'b1;
        chk("stmiss_c8_cwr_ack", CWR | ACK); cyc();
        req = 1'b0; hit = 1'b0;
        chk("stmiss_c9_idle", NONE); cyc();

        // Load miss served by victim swap
        req = 1'b1; wr = 1'b0; valid = 1'b1; evict = 1'b0; vhit = 1'b1;
        chk("swap_c1", NONE); cyc();
        chk("swap_c2_lookup", NONE); cyc();
        chk("swap_c3_strobes", TOV | FROMV); cyc();
        hit = 1'b1; vhit = 1'b0;
        chk("swap_c4_ack", ACK); cyc();
        req = 1'b0; hit = 1'b0;

        // Stray ack in IDLE is ignored
        mack = 1'b1;
        chk("idle_stray_ack", NONE); cyc();
        mack = 1'b0;
        chk("idle_after_stray", NONE); cyc();

        // Dirty miss with victim hit: writeback first, then swap
        req = 1'b1; valid = 1'b1; evict = 1'b1; vhit = 1'b1;
        chk("dirty_c1", NONE); cyc();
        chk("dirty_c2_lookup", NONE); cyc();
        chk("dirty_c3_wb", WRB | MREQ | MWR); cyc();
        chk("dirty_c4_wb", WRB | MREQ | MWR); cyc();
        mack = 1'b1;
        chk("dirty_c5_wb_ack", WRB | MREQ | MWR); cyc();
        mack = 1'b0; evict = 1'b0;
        chk("dirty_c6_relookup", NONE); cyc();
        chk("dirty_c7_swap", TOV | FROMV); cyc();
        hit = 1'b1; vhit = 1'b0;
        chk("dirty_c8_ack", ACK); cyc();
        req = 1'b0; hit = 1'b0;
        cyc();

        // Flush with a simultaneous request: flush wins, lines 1 and 3 dirty
        flush = 1'b1; req = 1'b1; wr = 1'b0; valid = 1'b1; evict = 1'b0;
        chk("flush_c1_idle", NONE); cyc();
        for (int i = 0; i < 4; i++) begin
            evict = 1'b0;
            chk($sformatf("flush_rd%0d", i), NONE);
            chk_idx($sformatf("flush_rd_idx%0d", i), 2'(i));
            cyc();
            evict = (i == 1 || i == 3);
            chk($sformatf("flush_chk%0d", i), NONE);
            chk_idx($sformatf("flush_chk_idx%0d", i), 2'(i));
            cyc();
            if (i == 1 || i == 3) begin
                evict = 1'b0;
                chk($sformatf("flush_wb%0d", i), WRB | MREQ | MWR);
                cyc();
                mack = 1'b1;
                chk($sformatf("flush_wb_ack%0d", i), WRB | MREQ | MWR | CLEAN);
                chk_idx($sformatf("flush_wb_idx%0d", i), 2'(i));
                cyc();
                mack = 1'b0;
            end
        end
        chk("flush_done_ack", FACK); cyc();
        flush = 1'b0;
        chk("flush_post_idle", NONE);
        chk_idx("flush_idx_wrapped", 2'd0);
        cyc();
        hit = 1'b1;
        chk("flush_then_req_ack", ACK); cyc();
        req = 1'b0; hit = 1'b0;
        cyc();

        // Reset in the middle of an allocate
        req = 1'b1; wr = 1'b1; valid = 1'b0; evict = 1'b0; vhit = 1'b0;
        chk("rst_c1", NONE); cyc();
        chk("rst_c2_lookup_invalid", NONE); cyc();
        chk("rst_c3_alloc", MREQ); cyc();
        rst_n = 1'b0;
        chk("rst_c4_alloc_hold", MREQ); cyc();
        rst_n = 1'b1; req = 1'b0; wr = 1'b0;
        chk("rst_c5_dropped", NONE);
        chk_idx("rst_c5_idx", 2'd0);
        cyc();
        mack = 1'b1;
        chk("rst_late_ack", NONE); cyc();
        mack = 1'b0;
        chk("rst_after_ack", NONE); cyc();
        hit = 1'b1; req = 1'b1;
        chk("rst_req_idle", NONE); cyc();
        chk("rst_wr_cleared_load_ack", ACK); cyc();
        req = 1'b0; hit = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
